spi_target: RTL and testbench

//  SPI mode-0 target (responder): the other end of the SoC's SD-card SPI master. Used as a

---
 rtl/spi_target.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_target.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target
//   SPI mode-0 target. Oversamples spi_cs/spi_sclk/spi_mosi on clk, assembles
//   MSB-first words from MOSI, and shifts words out on MISO from a one-entry
//   TX holding buffer. When the buffer is empty at a load point, FILL is sent
//   instead and tx_underrun pulses.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   spi_cs              chip select from master, active low, asynchronous
//   spi_sclk, spi_mosi  SPI clock (idles low) and master-out data
//   spi_miso            target-out data, 1 when not selected
//   rx_data, rx_valid   last completed word, 1-cycle update pulse
//   tx_data, tx_valid   holding-buffer write, accepted when tx_ready
//   tx_ready            holding buffer empty
//   tx_underrun         1-cycle pulse: FILL loaded because buffer empty
//   frame_abort         1-cycle pulse: cs rose with a partial word in flight
//   busy                synchronised chip select is active
module spi_target #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL        = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronisers and sclk edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] sync_live_q;
  logic                   sclk_prev_q;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sync_live;
  logic sclk_rise;
  logic sclk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sync_live_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sync_live_q <= {sync_live_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  // Synchroniser outputs only reflect real pin samples once the reset
  // values have been flushed through the chain.
  assign sync_live = sync_live_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // ---------------------------------------------------------------------
  // Frame state, shift registers and holding buffer
  // ---------------------------------------------------------------------
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rx_shift_q;
  // MSB of the outgoing word lives in miso_q; tx_shift_q holds the rest.
  logic [DATA_W-2:0]   tx_shift_q;
  logic                miso_q;
  logic [DATA_W-1:0]   buf_q;
  logic                buf_valid_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                underrun_q;
  logic                abort_q;
  logic                word_done_q;
  logic                armed_q;

  logic              reload;
  logic [DATA_W-1:0] reload_word;

  // A reload happens at LOAD and on the first sclk fall after a completed
  // word (count back at 0 while selected).
  always_comb begin
    reload = 1'b0;
    if (state_q == LOAD) begin
      reload = 1'b1;
    end else if (state_q == SHIFT && !cs_s && sclk_fall && cnt_q == '0) begin
      reload = 1'b1;
    end
  end

  assign reload_word = buf_valid_q ? buf_q : FILL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b1;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      word_done_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      word_done_q <= 1'b0;

      // After reset a frame may only start from a genuine cs high->low,
      // so cs must be seen high once before a low level is honoured.
      if (sync_live && cs_s) begin
        armed_q <= 1'b1;
      end

      // Word assembled on the previous cycle's sclk rise.
      if (word_done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b1;
          cnt_q  <= '0;
          if (armed_q && sync_live && !cs_s) begin
            state_q <= LOAD;
          end
        end

        LOAD: begin
          cnt_q   <= '0;
          state_q <= SHIFT;
        end

        SHIFT: begin
          if (cs_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b1;
            cnt_q   <= '0;
            if (cnt_q != '0) begin
              abort_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_q       <= '0;
              word_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall && cnt_q != '0) begin
            miso_q     <= tx_shift_q[DATA_W-2];
            tx_shift_q <= {tx_shift_q[DATA_W-3:0], 1'b0};
          end
        end

        default: begin
          state_q <= IDLE;
          miso_q  <= 1'b1;
        end
      endcase

      if (reload) begin
        miso_q     <= reload_word[DATA_W-1];
        tx_shift_q <= reload_word[DATA_W-2:0];
        if (buf_valid_q) begin
          buf_valid_q <= 1'b0;
        end else begin
          underrun_q <= 1'b1;
        end
      end

      // An empty buffer accepts tx_data even in a FILL reload cycle; the
      // new word is held for the next load point rather than bypassed.
      if (tx_valid && !buf_valid_q) begin
        buf_q       <= tx_data;
        buf_valid_q <= 1'b1;
      end
    end
  end

  assign spi_miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~buf_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;
  assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target
//   Self-checking bench for spi_target: drives an SPI mode-0 master with
//   wide sclk phases, keeps a model of the TX holding buffer, and checks
//   received words and MISO words against scoreboard queues.
module tb_spi_target;

  localparam int HP = 8;  // clk cycles per sclk phase

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  always #5 clk = ~clk;

  spi_target #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .FILL        (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboards and holding-buffer model
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  miso_exp_q[$];
  logic        mb_valid = 1'b0;
  logic [7:0]  mb_data  = 8'h00;
  int unsigned ur_exp   = 0;
  int unsigned ur_seen  = 0;
  int unsigned ab_seen  = 0;
  logic        rx_valid_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_exp_q.size() == 0) begin
        check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
      if (rx_valid_prev) begin
        check("rx_pulse_width", {31'd0, rx_valid_prev}, 32'd0);
      end
    end
    rx_valid_prev = rx_valid;
    if (tx_underrun) ur_seen++;
    if (frame_abort) ab_seen++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reload();
    if (mb_valid) begin
      miso_exp_q.push_back(mb_data);
      mb_valid = 1'b0;
    end else begin
      miso_exp_q.push_back(8'hFF);
      ur_exp++;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    check("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    mb_valid = 1'b1;
    mb_data  = d;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    model_reload();
    wait_clk(HP);
  endtask

  task automatic cs_high();
    wait_clk(HP);
    miso_exp_q.delete();
    spi_cs = 1'b1;
    wait_clk(HP);
  endtask

  // One full word; MISO sampled at each sclk rise.
  task automatic xfer(input logic [7:0] d);
    logic [7:0] got;
    got = 8'h00;
    rx_exp_q.push_back(d);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = d[i];
      wait_clk(HP);
      got      = {got[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clk(HP);
      spi_sclk = 1'b0;
    end
    if (miso_exp_q.size() == 0) begin
      check("miso_queue_empty", 32'(miso_exp_q.size()), 32'd1);
    end else begin
      check("miso_word", {24'd0, got}, {24'd0, miso_exp_q.pop_front()});
    end
    model_reload();  // trailing fall reloads the TX shifter
  endtask

  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = i[0];
      wait_clk(HP);
      spi_sclk = 1'b1;
      wait_clk(HP);
      spi_sclk = 1'b0;
    end
  endtask

  initial begin
    int unsigned ur_before;
    int unsigned ab_before;

    reset    = 1'b1;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    wait_clk(4);
    check("rst_miso",     {31'd0, spi_miso},    32'd1);
    check("rst_rx_data",  {24'd0, rx_data},     32'd0);
    check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
    check("rst_busy",     {31'd0, busy},        32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_abort",    {31'd0, frame_abort}, 32'd0);
    reset = 1'b0;
    wait_clk(HP);

    // 1: preloaded word out, 0xA5 in
    tx_write(8'h3C);
    check("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
    cs_low();
    check("t1_tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    xfer(8'hA5);
    cs_high();
    check("t1_ur_total", ur_seen, ur_exp);

    // 2: empty buffer, FILL out, underrun at LOAD
    ur_before = ur_seen;
    cs_low();
    check("t2_ur_at_load", ur_seen - ur_before, 32'd1);
    xfer(8'h00);
    cs_high();
    check("t2_ur_total", ur_seen, ur_exp);

    // 3: two words in one frame, second written after first consume
    tx_write(8'h56);
    cs_low();
    tx_write(8'h78);
    xfer(8'h12);
    xfer(8'h34);
    cs_high();
    check("t3_ur_total", ur_seen, ur_exp);

    // 4: abort after 5 sclk
    tx_write(8'h9A);
    ab_before = ab_seen;
    cs_low();
    sclk_pulses(5);
    cs_high();
    check("t4_abort_pulse", ab_seen - ab_before, 32'd1);
    check("t4_tx_ready", {31'd0, tx_ready}, 32'd1);
    cs_low();
    xfer(8'hC3);
    cs_high();
    check("t4_ur_total", ur_seen, ur_exp);

    // 5: reset mid-word
    tx_write(8'h11);
    cs_low();
    tx_write(8'h22);
    sclk_pulses(3);
    reset = 1'b1;
    wait_clk(1);
    check("t5_miso",     {31'd0, spi_miso},    32'd1);
    check("t5_rx_data",  {24'd0, rx_data},     32'd0);
    check("t5_rx_valid", {31'd0, rx_valid},    32'd0);
    check("t5_tx_ready", {31'd0, tx_ready},    32'd1);
    check("t5_underrun", {31'd0, tx_underrun}, 32'd0);
    check("t5_abort",    {31'd0, frame_abort}, 32'd0);
    check("t5_busy",     {31'd0, busy},        32'd0);
    mb_valid = 1'b0;
    miso_exp_q.delete();
    wait_clk(2);
    reset = 1'b0;
    ab_before = ab_seen;
    ur_before = ur_seen;
    sclk_pulses(5);
    check("t5_miso_idle", {31'd0, spi_miso}, 32'd1);
    cs_high();
    check("t5_no_abort",    ab_seen - ab_before, 32'd0);
    check("t5_no_underrun", ur_seen - ur_before, 32'd0);
    check("t5_rx_data_held", {24'd0, rx_data}, 32'd0);

    // 6: sclk activity while deselected
    tx_write(8'h44);
    for (int i = 0; i < 16; i++) begin
      wait_clk(HP);
      spi_sclk = 1'b1;
      wait_clk(HP);
      spi_sclk = 1'b0;
      if (i % 4 == 3) begin
        check("t6_miso", {31'd0, spi_miso}, 32'd1);
      end
    end
    wait_clk(HP);
    check("t6_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("t6_busy",     {31'd0, busy},     32'd0);

    // Leftover scoreboard state
    check("final_rx_pending", 32'(rx_exp_q.size()), 32'd0);
    check("final_ur_total", ur_seen, ur_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
